pim_final_accumulator: RTL and testbench
========================================

# pim_final_accumulator

Multi-channel, multi-beat successor to the PIM final positive/negative combine stage. Each channel accumulates a frame of `BEATS` partial-sum beats from the array's positive and negative bit-line adders, optionally weighting beat k by 2^k for bit-serial inputs. At the end of the frame it forms the signed difference and emits a saturated result in either sign-magnitude or two's-complement format. A valid/ready handshake on both sides lets it sit between the array readout and the output buffer.

## Interface
- `IN_W`, default 14: width of each per-channel pos/neg partial sum.
- `CH`, default 4: number of independent channels.
- `BEATS`, default 8: beats per frame; must be ≥1.
- `OUT_W`, default 16: result width per channel, sign included.
- `SHIFT_EN`, default 1: 1 = beat k weighted by 2^k; 0 = plain sum.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous abort of the frame in progress.
- `sm_mode`  in  1  output format: 1 = sign-magnitude (legacy format), 0 = two's complement; sampled on beat 0 of each frame.
- `in_valid`  in  1  beat valid.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`.
- `in_pos`  in  CH*IN_W  unsigned positive partial sums; channel c is at bits [c*IN_W +: IN_W].
- `in_neg`  in  CH*IN_W  unsigned negative partial sums; same packing as `in_pos`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed when `out_valid & out_ready`.
- `out_data`  out  CH*OUT_W  per-channel results; same packing as the inputs, with OUT_W per channel.
- `out_sat`  out  CH  per-channel saturation flag for the current result.

## Operation
- Per channel, there are two unsigned accumulators `acc_p` and `acc_n`, each ACC_W = IN_W+BEATS+1 bits wide.
- A 4-bit-or-wider `beat_cnt` runs 0..BEATS-1.
- State is ACCUM (`beat_cnt` and accumulators) plus the output register (HOLD whenever `out_valid`=1).
- Accepted beat k:
  - `acc_p += in_pos << (SHIFT_EN ? k : 0)`; `acc_n` is updated the same way from `in_neg`.
  - On beat 0 the accumulators load the term instead of adding to it, and `sm_mode` is latched.
- Accepted beat BEATS-1:
  - Final values are formed combinationally from the accumulators plus the current term.
  - d = acc_p − acc_n, signed, ACC_W+1 bits.
  - The result is registered into `out_data`/`out_sat`, `out_valid` is set, and `beat_cnt` returns to 0.
- Sign-magnitude mode:
  - mag = |d|, saturated to 2^(OUT_W-1)−1.
  - Output = {d<0, mag}.
  - d = 0 gives all zeros, with the sign bit 0.
- Two's-complement mode: d is clamped to [−2^(OUT_W-1), 2^(OUT_W-1)−1].
- `out_sat[c]` = 1 iff clamping occurred for channel c.
- Handshake:
  - `in_ready = !out_valid | out_ready | (beat_cnt != BEATS-1)`. Only the last beat stalls on a full output register.
  - `out_valid` clears on `out_valid & out_ready` unless a new final beat is accepted in the same cycle, in which case the register reloads and `out_valid` stays 1.
  - `out_data` and `out_sat` hold stable while `out_valid & !out_ready`.
- `flush`:
  - Sets `beat_cnt` to 0 and clears the accumulators.
  - A beat presented in the same cycle is discarded, even if `in_ready`=1.
  - Does not affect a pending output.
- BEATS=1: every accepted beat is a whole frame.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_sat`=0, `in_ready`=1, `beat_cnt`=0, accumulators 0.
- Reset mid-frame discards the partial frame and any pending result immediately (asynchronous).
- Latency: `out_valid` rises on the clock edge that accepts the last beat, so the result is visible the following cycle.
- Throughput: one beat per cycle, with no bubble between frames when `out_ready`=1.
- There is no combinational path from `in_*` to `out_*`.
- `in_ready` depends combinationally on `out_ready`.

## Test plan
Defaults apply unless stated: IN_W=14, CH=4, BEATS=8, OUT_W=16, SHIFT_EN=1.
- Reset: assert `rst` with the clock running -> `out_valid`=0, `out_data`=0, `out_sat`=0, `in_ready`=1.
- SM mode, 8 beats, ch0 pos=3/neg=1, ch1 pos=1/neg=3 -> ch0 `0x01FE`, ch1 `0x81FE`, `out_sat`=0. Same stimulus with `sm_mode`=0 -> ch1 `0xFE02`.
- pos=neg=100 on all beats and channels -> all outputs `0x0000` in both modes, `out_sat`=0.
- Saturation, ch0 pos=16383/neg=0 and ch1 pos=0/neg=16383:
  - SM mode -> ch0 `0x7FFF`, ch1 `0xFFFF`, `out_sat`=`0011`.
  - TC mode -> ch1 `0x8000`.
- Backpressure: hold `out_ready`=0 after frame 1 completes.
  - Frame 2 beats 0..6 are accepted; `in_ready`=0 while beat 7 is presented.
  - `out_data` is unchanged throughout.
  - Raising `out_ready` accepts beat 7 and reloads the output with `out_valid` continuously 1.
- `flush` after beat 3 while beat 4 is presented, then a fresh frame with SHIFT_EN=0, pos=5, neg=2 -> result 24 (`0x0018`); the beat-4 data does not appear in any result. Async `rst` mid-frame -> outputs return to their reset values on the same edge.

Source files
------------

// File: rtl/pim_final_accumulator.sv
// Multi-channel multi-beat PIM pos/neg accumulator with a saturated
// signed combine and valid/ready handshakes on both sides.
module pim_final_accumulator #(
   parameter int IN_W     = 14,
   parameter int CH       = 4,
   parameter int BEATS    = 8,
   parameter int OUT_W    = 16,
   parameter bit SHIFT_EN = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                sm_mode,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CH*IN_W-1:0]  in_pos,
   input  logic [CH*IN_W-1:0]  in_neg,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CH*OUT_W-1:0] out_data,
   output logic [CH-1:0]       out_sat
);
   localparam int ACC_W = IN_W + BEATS + 1;
   localparam int D_W   = ACC_W + 1;
   localparam int CNT_W = ($clog2(BEATS) > 4) ? $clog2(BEATS) : 4;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
   localparam logic signed [D_W-1:0] MAXP =
      D_W'((longint'(1) << (OUT_W - 1)) - 1);
   localparam logic signed [D_W-1:0] MINN = ~MAXP;

   logic [CNT_W-1:0]    r_cnt;
   logic                r_sm;
   logic [ACC_W-1:0]    r_accp [CH];
   logic [ACC_W-1:0]    r_accn [CH];
   logic                r_ovalid;
   logic [CH*OUT_W-1:0] r_odata;
   logic [CH-1:0]       r_osat;

   logic                w_first;
   logic                w_last;
   logic                w_fire;
   logic                w_sm;
   logic [CNT_W-1:0]    w_sh;
   logic [ACC_W-1:0]    w_sp [CH];
   logic [ACC_W-1:0]    w_sn [CH];
   logic [CH*OUT_W-1:0] w_data;
   logic [CH-1:0]       w_sat;

   assign w_first  = (r_cnt == '0);
   assign w_last   = (r_cnt == LAST);
   assign w_sh     = SHIFT_EN ? r_cnt : '0;
   assign w_sm     = w_first ? sm_mode : r_sm;
   assign in_ready = !r_ovalid | out_ready | !w_last;
   assign w_fire   = in_valid & in_ready & !flush;

   assign out_valid = r_ovalid;
   assign out_data  = r_odata;
   assign out_sat   = r_osat;

   always_comb begin
      logic [ACC_W-1:0]        w_tp;
      logic [ACC_W-1:0]        w_tn;
      logic signed [D_W-1:0]   w_d;
      logic [D_W-1:0]          w_abs;
      logic [OUT_W-1:0]        w_o;
      logic                    w_s;
      w_data = '0;
      w_sat  = '0;
      for (int c = 0; c < CH; c++) begin
         w_tp = ACC_W'(in_pos[c*IN_W +: IN_W]) << w_sh;
         w_tn = ACC_W'(in_neg[c*IN_W +: IN_W]) << w_sh;
         w_sp[c] = w_first ? w_tp : r_accp[c] + w_tp;
         w_sn[c] = w_first ? w_tn : r_accn[c] + w_tn;
         w_d = $signed({1'b0, w_sp[c]}) - $signed({1'b0, w_sn[c]});
         w_abs = w_d[D_W-1] ? -w_d : w_d;
         w_s = 1'b0;
         w_o = w_d[OUT_W-1:0];
         if (w_sm) begin
            // sign bit travels separately, magnitude saturates
            w_s = (w_abs > $unsigned(MAXP));
            w_o = w_s ? {w_d[D_W-1], MAXP[OUT_W-2:0]}
                      : {w_d[D_W-1], w_abs[OUT_W-2:0]};
         end else if (w_d > MAXP) begin
            w_s = 1'b1;
            w_o = MAXP[OUT_W-1:0];
         end else if (w_d < MINN) begin
            w_s = 1'b1;
            w_o = MINN[OUT_W-1:0];
         end
         w_data[c*OUT_W +: OUT_W] = w_o;
         w_sat[c] = w_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_sm     <= 1'b0;
         r_ovalid <= 1'b0;
         r_odata  <= '0;
         r_osat   <= '0;
         for (int c = 0; c < CH; c++) begin
            r_accp[c] <= '0;
            r_accn[c] <= '0;
         end
      end else begin
         if (r_ovalid & out_ready) r_ovalid <= 1'b0;
         if (flush) begin
            r_cnt <= '0;
            for (int c = 0; c < CH; c++) begin
               r_accp[c] <= '0;
               r_accn[c] <= '0;
            end
         end else if (w_fire) begin
            if (w_first) r_sm <= sm_mode;
            if (w_last) begin
               r_cnt    <= '0;
               r_odata  <= w_data;
               r_osat   <= w_sat;
               r_ovalid <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
               for (int c = 0; c < CH; c++) begin
                  r_accp[c] <= w_sp[c];
                  r_accn[c] <= w_sn[c];
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_pim_final_accumulator.sv
// Scoreboard bench for pim_final_accumulator: shifted and plain instances,
// directed frames with hand-computed results.
module tb_pim_final_accumulator;
   localparam int IN_W  = 14;
   localparam int CH    = 4;
   localparam int OUT_W = 16;
   localparam int EW    = CH*OUT_W + CH;

   logic clk, rst, flush, sm_mode, v1, v0, out_ready;
   logic [CH*IN_W-1:0] in_pos, in_neg;
   logic rdy1, rdy0, o_v1, o_v0;
   logic [CH*OUT_W-1:0] o_d1, o_d0;
   logic [CH-1:0] o_s1, o_s0;
   int n_vec, n_bad;
   logic [EW-1:0] q1[$];
   logic [EW-1:0] q0[$];

   pim_final_accumulator u_dut (
      .clk(clk), .rst(rst), .flush(flush), .sm_mode(sm_mode),
      .in_valid(v1), .in_ready(rdy1),
      .in_pos(in_pos), .in_neg(in_neg),
      .out_valid(o_v1), .out_ready(out_ready),
      .out_data(o_d1), .out_sat(o_s1)
   );

   pim_final_accumulator #(.SHIFT_EN(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .flush(flush), .sm_mode(sm_mode),
      .in_valid(v0), .in_ready(rdy0),
      .in_pos(in_pos), .in_neg(in_neg),
      .out_valid(o_v0), .out_ready(out_ready),
      .out_data(o_d0), .out_sat(o_s0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [127:0] act,
                        input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [CH*IN_W-1:0] pk(input int a0, a1, a2, a3);
      return {IN_W'(a3), IN_W'(a2), IN_W'(a1), IN_W'(a0)};
   endfunction

   always @(negedge clk) begin
      if (o_v1) begin
         if (q1.size() == 0) check("out1_unexpected", o_v1, 1'b0);
         else begin
            check("out1", {o_d1, o_s1}, q1[0]);
            if (out_ready) void'(q1.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (o_v0) begin
         if (q0.size() == 0) check("out0_unexpected", o_v0, 1'b0);
         else begin
            check("out0", {o_d0, o_s0}, q0[0]);
            if (out_ready) void'(q0.pop_front());
         end
      end
   end

   task automatic beat(input bit sel0, input logic [CH*IN_W-1:0] p,
                       input logic [CH*IN_W-1:0] n, input logic sm);
      in_pos  = p;
      in_neg  = n;
      sm_mode = sm;
      if (sel0) v0 = 1'b1;
      else v1 = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (sel0 ? rdy0 : rdy1) break;
         if (t == 99) check("beat_timeout", sel0 ? rdy0 : rdy1, 1'b1);
      end
      @(posedge clk);
      #1;
      v0 = 1'b0;
      v1 = 1'b0;
   endtask

   task automatic frame(input bit sel0, input logic [CH*IN_W-1:0] p,
                        input logic [CH*IN_W-1:0] n, input logic sm0,
                        input logic smr, input int nb,
                        input logic [CH*OUT_W-1:0] ed,
                        input logic [CH-1:0] es);
      for (int k = 0; k < nb; k++) begin
         if (k == 7) begin
            if (sel0) q0.push_back({ed, es});
            else q1.push_back({ed, es});
         end
         beat(sel0, p, n, (k == 0) ? sm0 : smr);
      end
   endtask

   localparam logic [63:0] E_SM  = 64'h0000_0000_81FE_01FE;
   localparam logic [63:0] E_TC  = 64'h0000_0000_FE02_01FE;
   localparam logic [63:0] E_SSM = 64'h0000_0000_FFFF_7FFF;
   localparam logic [63:0] E_STC = 64'h0000_0000_8000_7FFF;
   localparam logic [63:0] E_FL  = 64'h0000_7FFF_FFE8_0018;

   initial begin
      rst = 1'b1; flush = 1'b0; sm_mode = 1'b0;
      v1 = 1'b0; v0 = 1'b0; out_ready = 1'b1;
      in_pos = '0; in_neg = '0;
      n_vec = 0; n_bad = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", o_v1, 1'b0);
      check("rst_data", o_d1, 64'h0);
      check("rst_sat", o_s1, 4'h0);
      check("rst_ready", rdy1, 1'b1);
      check("rst_valid0", o_v0, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      frame(0, pk(3,1,0,0), pk(1,3,0,0), 1, 1, 8, E_SM, 4'b0000);
      frame(0, pk(3,1,0,0), pk(1,3,0,0), 0, 0, 8, E_TC, 4'b0000);
      frame(0, pk(100,100,100,100), pk(100,100,100,100), 1, 1, 8,
            64'h0, 4'b0000);
      frame(0, pk(100,100,100,100), pk(100,100,100,100), 0, 0, 8,
            64'h0, 4'b0000);
      frame(0, pk(16383,0,0,0), pk(0,16383,0,0), 1, 1, 8, E_SSM, 4'b0011);
      frame(0, pk(16383,0,0,0), pk(0,16383,0,0), 0, 0, 8, E_STC, 4'b0011);
      // sm_mode is only sampled on beat 0
      frame(0, pk(3,1,0,0), pk(1,3,0,0), 1, 0, 8, E_SM, 4'b0000);
      repeat (3) @(posedge clk);
      #1;

      out_ready = 1'b0;
      frame(0, pk(3,1,0,0), pk(1,3,0,0), 1, 1, 8, E_SM, 4'b0000);
      frame(0, pk(100,100,100,100), pk(100,100,100,100), 1, 1, 7,
            64'h0, 4'b0000);
      q1.push_back({64'h0, 4'b0000});
      in_pos = pk(100,100,100,100);
      in_neg = pk(100,100,100,100);
      v1 = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("bp_ready_low", rdy1, 1'b0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_ready_high", rdy1, 1'b1);
      @(posedge clk);
      #1;
      v1 = 1'b0;
      check("bp_valid_kept", o_v1, 1'b1);
      repeat (3) @(posedge clk);
      #1;

      for (int k = 0; k < 4; k++)
         beat(1, pk(1000,1000,1000,1000), pk(0,0,0,0), 0);
      in_pos = pk(9999,9999,9999,9999);
      v0 = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      v0 = 1'b0;
      frame(1, pk(5,2,16383,0), pk(2,5,0,0), 0, 0, 8, E_FL, 4'b0100);
      repeat (3) @(posedge clk);
      #1;

      out_ready = 1'b0;
      frame(0, pk(3,1,0,0), pk(1,3,0,0), 1, 1, 8, E_SM, 4'b0000);
      beat(0, pk(7,7,7,7), pk(1,1,1,1), 1);
      beat(0, pk(7,7,7,7), pk(1,1,1,1), 1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", o_v1, 1'b0);
      check("arst_data", o_d1, 64'h0);
      check("arst_sat", o_s1, 4'h0);
      check("arst_ready", rdy1, 1'b1);
      q1.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      frame(0, pk(3,1,0,0), pk(1,3,0,0), 0, 0, 8, E_TC, 4'b0000);

      for (int t = 0; t < 50 && (q0.size() + q1.size()) != 0; t++)
         @(posedge clk);
      #1;
      check("drain_q1", q1.size(), 0);
      check("drain_q0", q0.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
